// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Power-up and recovery sequencer for the board PLL wrapper. Holds the PLL in reset, waits for
//   lock, qualifies the lock as stable, then releases the downstream system reset. Loss of lock
//   in RUN re-runs the sequence; too many failed lock attempts latch a fault.
//   Single clock domain (refclk).
// Ports
//   i_refclk      reference clock, the only clock
//   i_rst         synchronous active-high reset
//   i_pll_locked  PLL lock flag, asynchronous, synchronized internally
//   i_relock_req  single-cycle pulse: restart the sequence, clear retries
//   o_pll_rst     reset to the PLL
//   o_sys_rst     reset to downstream logic, low only in RUN
//   o_ready       high only in RUN
//   o_fault       high only in FAULT
//   o_retry_cnt   failed lock attempts in this sequence
//   o_loss_cnt    lock-loss events seen in RUN, saturating at 255
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned LOCK_STABLE     = 64,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    localparam int unsigned RW             = $clog2(MAX_RETRIES + 1)
) (
    input  logic          i_refclk,
    input  logic          i_rst,
    input  logic          i_pll_locked,
    input  logic          i_relock_req,
    output logic          o_pll_rst,
    output logic          o_sys_rst,
    output logic          o_ready,
    output logic          o_fault,
    output logic [RW-1:0] o_retry_cnt,
    output logic [7:0]    o_loss_cnt
);

    localparam int unsigned HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;

    logic [2:0]    r_state, w_state_d;
    logic [HW-1:0] r_hold, w_hold_d;
    logic [TW-1:0] r_tmo, w_tmo_d, w_tmo_inc;
    logic [SW-1:0] r_stable, w_stable_d, w_stable_inc;
    logic [RW-1:0] r_retry, w_retry_d;
    logic [7:0]    r_loss, w_loss_d;
    logic          r_pll_rst, r_sys_rst, r_ready, r_fault;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Timeout saturates so repeated STABLE->WAIT bounces cannot wrap it.
    assign w_tmo_inc    = (r_tmo == TW'(LOCK_TIMEOUT)) ? r_tmo : r_tmo + 1'b1;
    assign w_stable_inc = r_stable + 1'b1;

    always_comb begin
        w_state_d  = r_state;
        w_hold_d   = '0;
        w_tmo_d    = r_tmo;
        w_stable_d = r_stable;
        w_retry_d  = r_retry;
        w_loss_d   = r_loss;
        if (i_relock_req) begin
            // Overrides any concurrent loss/timeout transition; loss_cnt untouched.
            w_state_d = S_RESET;
            w_retry_d = '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_hold == HW'(RST_HOLD_CYCLES - 1)) begin
                        w_state_d = S_WAIT_LOCK;
                        w_tmo_d   = '0;
                    end else begin
                        w_hold_d = r_hold + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    w_tmo_d = w_tmo_inc;
                    if (w_locked_s) begin
                        w_state_d  = S_STABLE;
                        w_stable_d = '0;
                    end else if (w_tmo_inc == TW'(LOCK_TIMEOUT)) begin
                        w_retry_d = r_retry + 1'b1;
                        w_state_d = (w_retry_d == RW'(MAX_RETRIES)) ? S_FAULT : S_RESET;
                    end
                end
                S_STABLE: begin
                    // Timeout counter deliberately left alone: it resumes in WAIT_LOCK.
                    if (!w_locked_s) begin
                        w_state_d = S_WAIT_LOCK;
                    end else begin
                        w_stable_d = w_stable_inc;
                        if (w_stable_inc == SW'(LOCK_STABLE)) begin
                            w_state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_state_d = S_RESET;
                        w_loss_d  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end
                end
                S_FAULT: begin
                    w_state_d = S_FAULT;
                end
                default: begin
                    w_state_d = S_RESET;
                end
            endcase
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_state   <= S_RESET;
            r_hold    <= '0;
            r_tmo     <= '0;
            r_stable  <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
            r_state   <= w_state_d;
            r_hold    <= w_hold_d;
            r_tmo     <= w_tmo_d;
            r_stable  <= w_stable_d;
            r_retry   <= w_retry_d;
            r_loss    <= w_loss_d;
            // Registered decode of the next state, so outputs track the state register exactly.
            r_pll_rst <= (w_state_d == S_RESET) || (w_state_d == S_FAULT);
            r_sys_rst <= (w_state_d != S_RUN);
            r_ready   <= (w_state_d == S_RUN);
            r_fault   <= (w_state_d == S_FAULT);
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst   = r_sys_rst;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_retry_cnt = r_retry;
    assign o_loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: phase-level reference model checked every cycle, plus
// hand-computed latency and counter expectations for the directed scenarios.
module tb_pll_lock_sequencer;

    localparam int RST_HOLD = 4;
    localparam int TIMEOUT  = 20;
    localparam int STABLE   = 8;
    localparam int RETRIES  = 2;
    localparam int SYNC     = 2;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES(RST_HOLD),
        .LOCK_TIMEOUT   (TIMEOUT),
        .LOCK_STABLE    (STABLE),
        .MAX_RETRIES    (RETRIES),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .i_refclk    (clk),
        .i_rst       (rst),
        .i_pll_locked(pll_locked),
        .i_relock_req(relock_req),
        .o_pll_rst   (pll_rst),
        .o_sys_rst   (sys_rst),
        .o_ready     (ready),
        .o_fault     (fault),
        .o_retry_cnt (retry_cnt),
        .o_loss_cnt  (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which phase of the sequence we are in, plus cycle tallies.
    typedef enum {PhReset, PhWait, PhStable, PhRun, PhFault} phase_t;
    phase_t m_phase = PhReset;
    int     m_hold, m_waited, m_stable, m_retries, m_losses;
    bit     m_hist[$];
    bit     m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit ls;
        if (rst) begin
            m_phase   = PhReset;
            m_hold    = 0;
            m_waited  = 0;
            m_stable  = 0;
            m_retries = 0;
            m_losses  = 0;
            m_hist    = {};
            for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
            m_valid   = 1'b1;
        end else if (m_valid) begin
            // The FSM sees pll_locked as it was SYNC edges ago.
            ls = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            if (relock_req) begin
                m_phase   = PhReset;
                m_hold    = 0;
                m_retries = 0;
            end else begin
                case (m_phase)
                    PhReset: begin
                        m_hold++;
                        if (m_hold == RST_HOLD) begin
                            m_phase  = PhWait;
                            m_hold   = 0;
                            m_waited = 0;
                        end
                    end
                    PhWait: begin
                        m_waited = (m_waited < TIMEOUT) ? m_waited + 1 : TIMEOUT;
                        if (ls) begin
                            m_phase  = PhStable;
                            m_stable = 0;
                        end else if (m_waited == TIMEOUT) begin
                            m_retries++;
                            m_hold  = 0;
                            m_phase = (m_retries == RETRIES) ? PhFault : PhReset;
                        end
                    end
                    PhStable: begin
                        if (!ls) m_phase = PhWait;
                        else begin
                            m_stable++;
                            if (m_stable == STABLE) m_phase = PhRun;
                        end
                    end
                    PhRun: begin
                        if (!ls) begin
                            m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                            m_phase  = PhReset;
                            m_hold   = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [13:0] exp_v, act_v;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return ready == 1'b1;
            1:       return sys_rst == 1'b1;
            2:       return pll_rst == 1'b1;
            3:       return fault == 1'b1;
            default: return pll_rst == 1'b0;
        endcase
    endfunction

    // Negedges elapsed until the selected condition holds; 200 means it never did.
    task automatic cycles_until(input int which, output int n);
        n = 0;
        while (!sig(which) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (m_valid) begin
                    exp_v = {(m_phase == PhReset) || (m_phase == PhFault), m_phase != PhRun,
                             m_phase == PhRun, m_phase == PhFault, 2'(m_retries), 8'(m_losses)};
                    act_v = {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};
                    n_cmp++;
                    if (act_v !== exp_v) begin
                        n_bad++;
                        $display("FAIL model @%0t {pll_rst,sys_rst,ready,fault,retry,loss}: actual=%b required=%b",
                                 $time, act_v, exp_v);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);

        // 1: power-up with lock 3 cycles after pll_rst falls
        rst = 1'b0;
        cycles_until(4, n);
        check("t1 pll_rst high cycles", n, 4);
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        cycles_until(0, n);
        check("t1 lock-to-ready", n, 11);
        check("t1 sys_rst", int'(sys_rst), 0);
        check("t1 retry_cnt", int'(retry_cnt), 0);

        // 3: one-cycle lock drop in RUN
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        cycles_until(1, n);
        check("t3 drop-to-sys_rst", n + 1, 3);
        check("t3 ready low", int'(ready), 0);
        check("t3 loss_cnt", int'(loss_cnt), 1);
        cycles_until(0, n);
        check("t3 resequence-to-ready", n, 13);

        // 4a: glitch while stable count is 5
        repeat (2) @(negedge clk);
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
        repeat (8) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        cycles_until(0, n);
        check("t4a restore-to-ready", n, 11);
        check("t4a loss_cnt", int'(loss_cnt), 1);

        // 4b: fall back to WAIT_LOCK keeps the timeout already spent
        repeat (2) @(negedge clk);
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
        repeat (6) @(negedge clk);
        pll_locked = 1'b0;
        cycles_until(2, n);
        check("t4b drop-to-timeout", n, 22);
        check("t4b retry_cnt", int'(retry_cnt), 1);
        pll_locked = 1'b1;
        cycles_until(0, n);
        check("t4b retry-to-ready", n, 13);
        check("t4b retry_cnt in run", int'(retry_cnt), 1);

        // 6a: relock_req on the same cycle the synced lock falls in RUN
        repeat (2) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
        pll_locked = 1'b1;
        check("t6a pll_rst", int'(pll_rst), 1);
        check("t6a ready", int'(ready), 0);
        check("t6a retry_cnt", int'(retry_cnt), 0);
        check("t6a loss_cnt kept", int'(loss_cnt), 1);

        // 6b: synchronous reset in the middle of STABLE
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6b outputs after rst", int'({pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt}),
              int'(14'b1100_00_00000000));
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);

        // 2: lock never comes
        rst = 1'b0;
        cycles_until(3, n);
        check("t2 release-to-fault", n, 48);
        check("t2 retry_cnt", int'(retry_cnt), 2);
        repeat (30) @(negedge clk);
        check("t2 fault held", int'(fault), 1);
        check("t2 sys_rst held", int'(sys_rst), 1);

        // 5: recover from FAULT with relock_req
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
        check("t5 fault cleared", int'(fault), 0);
        check("t5 retry_cnt", int'(retry_cnt), 0);
        check("t5 pll_rst", int'(pll_rst), 1);
        cycles_until(0, n);
        check("t5 relock-to-ready", n, 13);
        check("t5 loss_cnt", int'(loss_cnt), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
